// File: rtl/bram_reader.sv
// bram_reader: sweeps every BRAM address through a read port and streams the
// words out on an AXI4-Stream master. A small prefetch FIFO absorbs the BRAM
// read latency so full throughput is kept with tready high. Reads are issued
// only while the FIFO can hold every outstanding word, so it never overflows.
module bram_reader #(
  parameter int BRAM_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  loop,
  output logic [BRAM_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  // Buffer holds every in-flight read plus slack for back-to-back streaming.
  localparam int BUF_DEPTH = READ_LATENCY + 2;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(2 * BUF_DEPTH + 1);
  localparam logic [BRAM_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [BRAM_WIDTH-1:0]   addr_q, addr_d;

  // Read-return tracking: bit k set means a read issued k cycles ago.
  logic [READ_LATENCY:1]   vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY:1]   last_pipe_q, last_pipe_d;

  // Prefetch FIFO.
  logic [DATA_WIDTH-1:0]   data_mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]    last_mem_q, last_mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           occ_q, occ_d;

  logic [CW-1:0]           inflight;
  logic [CW-1:0]           pending;
  logic                    room;
  logic                    issue;
  logic                    push;
  logic                    push_last;
  logic                    pop;
  logic                    fin;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= READ_LATENCY; k++)
      inflight = inflight + CW'(vld_pipe_q[k]);
  end

  assign pending = occ_q + inflight;
  assign room    = (pending < CW'(BUF_DEPTH));

  // Sequencer: next state, read issue, address advance, completion.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (room) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          // loop only matters on the final address of a pass.
          if (addr_q == ADDR_LAST && !loop)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_q == '0 && inflight == '0) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift issued reads (with their last-address tag) toward the return point.
  always_comb begin
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[1]  = issue;
    last_pipe_d[1] = issue && (addr_q == ADDR_LAST);
    for (int k = 2; k <= READ_LATENCY; k++) begin
      vld_pipe_d[k]  = vld_pipe_q[k-1];
      last_pipe_d[k] = last_pipe_q[k-1];
    end
  end

  assign push      = vld_pipe_q[READ_LATENCY];
  assign push_last = last_pipe_q[READ_LATENCY];
  assign pop       = m_axis_tvalid && m_axis_tready;

  // FIFO update: capture returning data, retire the head on a handshake.
  always_comb begin
    data_mem_d = data_mem_q;
    last_mem_d = last_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = bram_rddata;
      last_mem_d[wr_ptr_q] = push_last;
      wr_ptr_d             = nxt_ptr(wr_ptr_q);
    end
    if (pop)
      rd_ptr_d = nxt_ptr(rd_ptr_q);
    occ_d = occ_q + CW'(push) - CW'(pop);
  end

  // State registers; reset also discards any reads still in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) data_mem_q[i] <= '0;
      last_mem_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      data_mem_q  <= data_mem_d;
      last_mem_q  <= last_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  assign bram_en       = issue;
  assign bram_addr     = addr_q;
  assign m_axis_tvalid = (occ_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? data_mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_mem_q[rd_ptr_q];
  assign done          = fin;
  assign busy          = (state_q != S_IDLE) && !fin;

endmodule

// File: tb/tb_bram_reader.sv
// Bench for bram_reader: three instances (read latency 1, 2, 3) share one
// directed stimulus; each has its own BRAM model and tready. A stream-level
// model (expected word k = f(k mod 16)) is checked every cycle.
module tb_bram_reader;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0, start = 1'b0, loop = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] addr  [NI];
  logic          en    [NI];
  logic [DW-1:0] rdata [NI];
  logic [DW-1:0] tdata [NI];
  logic          tvalid[NI], tlast[NI], busy[NI], done[NI];
  logic [NI-1:0] tready;

  function automatic logic [31:0] f(input int a);
    return 32'hA500_0000 | 32'(a % 16);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = g + 1;
    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= en[g] ? f(int'(addr[g])) : 32'hDEAD_BEEF;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata[g] = pipe[L-1];
    bram_reader #(.BRAM_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
      .clk(clk), .resetn(resetn), .start(start), .loop(loop),
      .bram_addr(addr[g]), .bram_en(en[g]), .bram_rddata(rdata[g]),
      .m_axis_tdata(tdata[g]), .m_axis_tvalid(tvalid[g]),
      .m_axis_tready(tready[g]), .m_axis_tlast(tlast[g]),
      .busy(busy[g]), .done(done[g]));
  end

  // Stimulus-side control
  int   mode = 0;          // 0: tready=1, 1: pseudo-random, 2: ready for 7 words then stall
  int   exp_total = 16;
  bit   lit_on = 1'b0;
  bit   clr = 1'b0;
  bit   chk_fin = 1'b0;
  int   start_cyc = 0;

  // Edge-sampled bench state
  int          cyc = 0;
  bit          rst_s = 1'b0, start_s = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  int          xcnt [NI];

  always_comb
    for (int g = 0; g < NI; g++)
      tready[g] = (mode == 0) || (mode == 1 && lfsr[g*5]) || (mode == 2 && xcnt[g] < 7);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_s   <= !resetn;
    start_s <= start && resetn;
    lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    for (int g = 0; g < NI; g++)
      if (clr || !resetn) xcnt[g] <= 0;
      else if (tvalid[g] && tready[g]) xcnt[g] <= xcnt[g] + 1;
  end

  // Model state and counters
  int            n_vec = 0, n_bad = 0;
  int            idx [NI], iss [NI];
  bit            active [NI], pend [NI], pstall [NI], seen1 [NI];
  logic [DW-1:0] pdata [NI];
  logic          plast [NI];
  logic [NI-1:0] fin = '0;
  bit            armed = 1'b0;
  int            first_exp [NI] = '{3, 4, 5};
  int            done_exp  [NI] = '{19, 20, 21};

  task automatic chk(input bit ok, input string nm, input int g,
                     input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s inst%0d (lat %0d) cyc %0d: got %0h want %0h",
               nm, g, g + 1, cyc, act, exp);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (chk_fin) chk(fin == '1, "all_done", 0, 64'(fin), 64'(3'b111));
    if (rst_s) armed = 1'b1;
    if (armed) for (int g = 0; g < NI; g++) begin
      if (rst_s) begin
        chk(!tvalid[g] && !tlast[g] && tdata[g] == 0 && !en[g] && addr[g] == 0 &&
            !busy[g] && !done[g], "reset_outputs", g,
            {tdata[g], 8'(addr[g]), en[g], tvalid[g], tlast[g], busy[g], done[g]}, 64'd0);
        idx[g] = 0; iss[g] = 0; active[g] = 0; pend[g] = 0; pstall[g] = 0;
        seen1[g] = 0; fin[g] = 0;
      end else begin
        if (clr) begin
          idx[g] = 0; iss[g] = 0; pend[g] = 0; seen1[g] = 0; fin[g] = 0;
        end
        if (start_s && !active[g]) active[g] = 1'b1;
        chk(done[g] == pend[g], "done", g, 64'(done[g]), 64'(pend[g]));
        if (pend[g]) begin
          active[g] = 1'b0;
          fin[g]    = 1'b1;
          if (lit_on) chk(cyc - start_cyc == done_exp[g], "done_cycle", g,
                          64'(cyc - start_cyc), 64'(done_exp[g]));
        end
        pend[g] = 1'b0;
        chk(busy[g] == active[g], "busy", g, 64'(busy[g]), 64'(active[g]));
        if (!active[g]) chk(!en[g], "en_idle", g, 64'(en[g]), 64'd0);
        if (en[g]) begin
          chk(int'(addr[g]) == iss[g] % 16, "bram_addr", g, 64'(addr[g]), 64'(iss[g] % 16));
          chk(iss[g] - idx[g] < g + 3, "buf_bound", g, 64'(iss[g] - idx[g]), 64'(g + 3));
          iss[g]++;
        end
        if (pstall[g])
          chk(tvalid[g] && tdata[g] == pdata[g] && tlast[g] == plast[g], "stall_hold", g,
              {tvalid[g], tlast[g], tdata[g]}, {1'b1, plast[g], pdata[g]});
        if (idx[g] >= exp_total)
          chk(!tvalid[g], "no_extra", g, 64'(tvalid[g]), 64'd0);
        else if (mode == 0 && idx[g] > 0 && active[g])
          chk(tvalid[g], "no_bubble", g, 64'(tvalid[g]), 64'd1);
        if (tvalid[g] && !seen1[g]) begin
          seen1[g] = 1'b1;
          if (lit_on) begin
            chk(cyc - start_cyc == first_exp[g], "first_valid_cycle", g,
                64'(cyc - start_cyc), 64'(first_exp[g]));
            chk(tdata[g] == 32'hA500_0000, "first_word", g, 64'(tdata[g]), 64'h A500_0000);
          end
        end
        if (tvalid[g] && tready[g]) begin
          chk(tdata[g] == f(idx[g]), "tdata", g, 64'(tdata[g]), 64'(f(idx[g])));
          chk(tlast[g] == (idx[g] % 16 == 15), "tlast", g, 64'(tlast[g]),
              64'(idx[g] % 16 == 15));
          idx[g]++;
          if (idx[g] == exp_total) pend[g] = 1'b1;
        end
        pstall[g] = tvalid[g] && !tready[g];
        pdata[g]  = tdata[g];
        plast[g]  = tlast[g];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setup(input int m, input int tot, input bit lit);
    mode = m; exp_total = tot; lit_on = lit; clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start_cyc = cyc; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_fin();
    for (int t = 0; t < 400 && fin != '1; t++) tick(1);
    chk_fin = 1'b1;
    tick(1);
    chk_fin = 1'b0;
  endtask

  initial begin
    tick(3);
    resetn = 1'b1;
    tick(2);
    // full-rate single pass, cycle-exact latency and done timing
    setup(0, 16, 1'b1); pulse_start(); wait_fin();
    // random backpressure
    setup(1, 16, 1'b0); pulse_start(); wait_fin();
    // loop for 2.5 passes, then release loop: three full passes
    setup(0, 48, 1'b0); loop = 1'b1; pulse_start(); tick(39); loop = 1'b0; wait_fin();
    // start re-pulsed mid-pass (cycle 8) and during drain (cycle 18)
    setup(0, 16, 1'b1); pulse_start(); tick(7);
    start = 1'b1; tick(1); start = 1'b0; tick(9);
    start = 1'b1; tick(1); start = 1'b0; wait_fin();
    // stall at word 7, reset mid-pass, then a clean pass
    setup(2, 16, 1'b0); pulse_start(); tick(30);
    resetn = 1'b0; tick(1); resetn = 1'b1; tick(2);
    setup(0, 16, 1'b0); pulse_start(); wait_fin();
    // second random-backpressure pass with a different ready phase
    tick(5);
    setup(1, 16, 1'b0); pulse_start(); wait_fin();
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
